// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller takes the master view: it reads decode fields and drives selects/strobes.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ImmSrc;
   logic [2:0] ALUControl;
   logic       RegWrite;
   logic       IllegalInstr;

   modport master (
      input  op, funct3, funct7b5, Zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUControl, RegWrite, IllegalInstr
   );

   modport slave (
      output op, funct3, funct7b5, Zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUControl, RegWrite, IllegalInstr
   );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the RV32I multi-cycle core: sequences fetch/decode/execute/memory/
// writeback over the shared PC, ALU and memory, and traps on unsupported instructions.
module multicycle_controller (
   input logic                    clk,
   input logic                    reset,
   multicycle_controller_if.master bus
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
      ALUWB, BRANCH, JAL, JALR, JALRWB, LUI, AUIPC, TRAP
   } stateType;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   stateType   state;
   stateType   nextState;
   logic       trapFlag;
   logic       functSupported;
   logic [2:0] functAlu;
   logic [2:0] immSel;

   logic       pcWrite;
   logic       adrSrc;
   logic       memWrite;
   logic       irWrite;
   logic [1:0] resultSrc;
   logic [1:0] aluSrcA;
   logic [1:0] aluSrcB;
   logic [2:0] aluControl;
   logic       regWrite;

   // State register; reset drops straight back to FETCH from anywhere.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= nextState;
      end
   end

   // Sticky trap flag, raised together with the move into TRAP so it is visible in the TRAP cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trapFlag <= 1'b0;
      end else if (nextState == TRAP) begin
         trapFlag <= 1'b1;
      end
   end

   // ALU function decode shared by register and immediate arithmetic; sltu and sra are not supported.
   always_comb begin
      functAlu       = ALU_ADD;
      functSupported = 1'b1;
      case (bus.funct3)
         3'b000:  functAlu = (bus.op[5] && bus.funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  functAlu = ALU_SLL;
         3'b010:  functAlu = ALU_SLT;
         3'b011:  functSupported = 1'b0;
         3'b100:  functAlu = ALU_XOR;
         3'b101: begin
            functAlu       = ALU_SRL;
            functSupported = !bus.funct7b5;
         end
         3'b110:  functAlu = ALU_OR;
         3'b111:  functAlu = ALU_AND;
         default: functAlu = ALU_ADD;
      endcase
   end

   // Immediate format is a pure function of the opcode.
   always_comb begin
      immSel = 3'b000;
      case (bus.op)
         OP_LOAD, OP_ITYPE, OP_JALR: immSel = 3'b000;
         OP_STORE:                   immSel = 3'b001;
         OP_BRANCH:                  immSel = 3'b010;
         OP_JAL:                     immSel = 3'b011;
         OP_LUI, OP_AUIPC:           immSel = 3'b100;
         default:                    immSel = 3'b000;
      endcase
   end

   // Next-state logic; all instruction dispatch happens out of DECODE.
   always_comb begin
      nextState = state;
      case (state)
         FETCH:  nextState = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: nextState = MEMADR;
               OP_RTYPE:          nextState = functSupported ? EXECUTER : TRAP;
               OP_ITYPE:          nextState = functSupported ? EXECUTEI : TRAP;
               OP_BRANCH:         nextState = (bus.funct3[2:1] == 2'b00) ? BRANCH : TRAP;
               OP_JAL:            nextState = JAL;
               OP_JALR:           nextState = JALR;
               OP_LUI:            nextState = LUI;
               OP_AUIPC:          nextState = AUIPC;
               default:           nextState = TRAP;
            endcase
         end
         MEMADR:   nextState = bus.op[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  nextState = MEMWB;
         MEMWB:    nextState = FETCH;
         MEMWRITE: nextState = FETCH;
         EXECUTER: nextState = ALUWB;
         EXECUTEI: nextState = ALUWB;
         ALUWB:    nextState = FETCH;
         BRANCH:   nextState = FETCH;
         JAL:      nextState = ALUWB;
         JALR:     nextState = JALRWB;
         JALRWB:   nextState = FETCH;
         LUI:      nextState = ALUWB;
         AUIPC:    nextState = ALUWB;
         TRAP:     nextState = TRAP;
         default:  nextState = FETCH;
      endcase
   end

   // Moore outputs per state; only the branch PC enable and the execute ALU function look at inputs.
   always_comb begin
      pcWrite    = 1'b0;
      adrSrc     = 1'b0;
      memWrite   = 1'b0;
      irWrite    = 1'b0;
      resultSrc  = 2'b00;
      aluSrcA    = 2'b00;
      aluSrcB    = 2'b00;
      aluControl = ALU_ADD;
      regWrite   = 1'b0;
      case (state)
         FETCH: begin
            irWrite   = 1'b1;
            aluSrcB   = 2'b10;
            resultSrc = 2'b10;
            pcWrite   = 1'b1;
         end
         DECODE: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b01;
         end
         MEMADR: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
         end
         MEMREAD: adrSrc = 1'b1;
         MEMWB: begin
            resultSrc = 2'b01;
            regWrite  = 1'b1;
         end
         MEMWRITE: begin
            adrSrc   = 1'b1;
            memWrite = 1'b1;
         end
         EXECUTER: begin
            aluSrcA    = 2'b10;
            aluControl = functAlu;
         end
         EXECUTEI: begin
            aluSrcA    = 2'b10;
            aluSrcB    = 2'b01;
            aluControl = functAlu;
         end
         ALUWB: regWrite = 1'b1;
         BRANCH: begin
            aluSrcA    = 2'b10;
            aluControl = ALU_SUB;
            pcWrite    = bus.Zero ^ bus.funct3[0];
         end
         JAL: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b10;
            pcWrite = 1'b1;
         end
         JALR: begin
            aluSrcA   = 2'b10;
            aluSrcB   = 2'b01;
            resultSrc = 2'b10;
            pcWrite   = 1'b1;
         end
         JALRWB: begin
            aluSrcA   = 2'b01;
            aluSrcB   = 2'b10;
            resultSrc = 2'b10;
            regWrite  = 1'b1;
         end
         LUI: begin
            aluSrcA = 2'b11;
            aluSrcB = 2'b01;
         end
         AUIPC: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b01;
         end
         default: begin
            pcWrite = 1'b0;
         end
      endcase
   end

   assign bus.PCWrite      = pcWrite;
   assign bus.AdrSrc       = adrSrc;
   assign bus.MemWrite     = memWrite;
   assign bus.IRWrite      = irWrite;
   assign bus.ResultSrc    = resultSrc;
   assign bus.ALUSrcA      = aluSrcA;
   assign bus.ALUSrcB      = aluSrcB;
   assign bus.ImmSrc       = immSel;
   assign bus.ALUControl   = aluControl;
   assign bus.RegWrite     = regWrite;
   assign bus.IllegalInstr = trapFlag;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the RV32I multi-cycle core.
- Sequences fetch, decode, execute, memory and writeback over shared PC/ALU/memory resources.
- Decodes opcode, funct3 and funct7[5] into datapath selects, including ImmSrc for the immediate extender and ALUControl.
- Flags unsupported instructions with a sticky trap.

Parameters:
- none.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH
- op  input  7  Instr[6:0], valid from DECODE onward (IR latched in FETCH)
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag, current cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  IR/OldPC latch enable
- ResultSrc  output  2  00=ALUOut, 01=MemData, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=A (rs1), 11=zero
- ALUSrcB  output  2  00=B (rs2), 01=ImmExt, 10=constant 4
- ImmSrc  output  3  000=I, 001=S, 010=B, 011=J, 100=U
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- RegWrite  output  1  register file write enable
- IllegalInstr  output  1  sticky trap flag

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, JALRWB, LUI, AUIPC, TRAP.
- Outputs are Moore, a function of state only. Exceptions: ImmSrc and ALUControl also depend on op, funct3 and funct7b5. The PCWrite branch term depends on Zero.
- Strobes not listed for a state are 0. Select fields not listed are 00.
- During and immediately after reset: state = FETCH, IllegalInstr = 0. Outputs therefore show the FETCH values.
- FETCH:
  - AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1.
  - Next: DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add. ALUOut = OldPC + imm, the branch/JAL target.
  - Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 with funct3 in {000, 001} -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next: FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, function from funct3/funct7b5. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, function from funct3. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = Zero XOR funct3[0] (beq when funct3[0]=0, bne when 1).
  - Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB, which writes OldPC+4.
- JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1. Next: JALRWB.
- JALRWB: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1. Next: FETCH.
- LUI: ALUSrcA=11, ALUSrcB=01, add. Next: ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, add. Next: ALUWB.
- TRAP: IllegalInstr=1, all strobes 0. Stays in TRAP until reset.
- ImmSrc by op: I for load, OP-IMM and JALR; S for store; B for branch; J for JAL; U for LUI and AUIPC; 000 otherwise.
- ALUControl, funct decode (R-type and I-type):
  - funct3 000: add, or sub when op[5] and funct7b5 are both 1.
  - 001 sll, 010 slt, 100 xor, 110 or, 111 and.
  - 101: srl. funct7b5=1 (sra) -> TRAP from DECODE.
  - 011 (sltu) -> TRAP from DECODE.
  - In all non-execute states ALUControl is as listed per state; default add.
- Cycle counts: load 5, store 4, R/I-type 4, branch 3, JAL 4, JALR 4, LUI/AUIPC 4.
- Reset asserted in any state: immediate return to FETCH, no further strobes. MemWrite is guaranteed low in the reset cycle.

Test Plan:
- Reset, then `lw` (op 0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in cycle 5 with ResultSrc=01; ImmSrc=000.
- `sw` (0100011): MemWrite=1 in cycle 4 only, AdrSrc=1, ImmSrc=001; RegWrite never asserted.
- `beq` with Zero=1 then Zero=0: PCWrite=1 in cycle 3, then 0; `bne` inverts this. ImmSrc=010.
- `sub` (funct3 000, funct7b5=1, op 0110011): ALUControl=001 in EXECUTER; the same fields with op 0010011 give 000.
- `jalr`, then `lui`: JALR has PCWrite=1 and ResultSrc=10; JALRWB has RegWrite=1 and ALUSrcA=01. LUI has ALUSrcA=11 and ImmSrc=100.
- Opcode 1111111: IllegalInstr=1 from cycle 3 onward and stays high for 20 cycles. Async reset mid-MEMWRITE clears it, drops MemWrite the same cycle, and the next state is FETCH.
